// File: rtl/vga_sync_module.sv
// vga_sync_module: free-running VGA timing generator.
// Counts pixels (h_cnt) and lines (v_cnt) and registers, one CLK after the
// counter state they describe:
//   Ready_Sig        1 while the current pixel is visible
//   Column_Addr_Sig  visible column, 0 outside the visible area
//   Row_Addr_Sig     visible row, 0 outside the visible area
//   HSYNC_Sig        horizontal sync (level H_POL), plus SYNC_DLY extra CLKs
//   VSYNC_Sig        vertical sync (level V_POL), plus SYNC_DLY extra CLKs
//   Frame_Start      one-CLK pulse on the pixel enable at (0,0)
// Inputs: CLK, RSTn (asynchronous, active-low).
module vga_sync_module #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FRONT  = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 23,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic        Ready_Sig,
  output logic [10:0] Column_Addr_Sig,
  output logic [10:0] Row_Addr_Sig,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Frame_Start
);

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END  = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END  = V_ACTIVE + V_FRONT + V_SYNC;
  localparam int unsigned PIPE_W  = SYNC_DLY + 1;

  // Elaboration-time parameter sanity checks.
  generate
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
      $error("vga_sync_module: H_TOTAL/V_TOTAL must fit 11-bit counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_module: CLK_DIV must be 1..16");
    end
    if (SYNC_DLY > 4) begin : g_bad_dly
      $error("vga_sync_module: SYNC_DLY must be 0..4");
    end
  endgenerate

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0] h_cnt_q, h_cnt_d;
  logic [ADDR_W-1:0] v_cnt_q, v_cnt_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              fs_q, fs_d;
  logic [PIPE_W-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_W-1:0] vs_pipe_q, vs_pipe_d;

  logic pix_en_c;
  logic h_wrap_c;
  logic v_wrap_c;
  logic visible_c;
  logic hs_lvl_c;
  logic vs_lvl_c;

  // Pixel enable and timing decode from the current counter state.
  always_comb begin
    pix_en_c  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    h_wrap_c  = (h_cnt_q == ADDR_W'(H_TOTAL - 1));
    v_wrap_c  = (v_cnt_q == ADDR_W'(V_TOTAL - 1));
    visible_c = (h_cnt_q < ADDR_W'(H_ACTIVE)) && (v_cnt_q < ADDR_W'(V_ACTIVE));
    hs_lvl_c  = ((h_cnt_q >= ADDR_W'(HS_BEG)) && (h_cnt_q < ADDR_W'(HS_END))) ? H_POL : ~H_POL;
    vs_lvl_c  = ((v_cnt_q >= ADDR_W'(VS_BEG)) && (v_cnt_q < ADDR_W'(VS_END))) ? V_POL : ~V_POL;
  end

  // Counter next state: line advances only on the pixel that wraps h_cnt.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en_c) begin
      div_cnt_d = '0;
      if (h_wrap_c) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap_c ? '0 : v_cnt_q + ADDR_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Output register inputs.
  always_comb begin
    ready_d = visible_c;
    col_d   = visible_c ? h_cnt_q : '0;
    row_d   = visible_c ? v_cnt_q : '0;
    fs_d    = pix_en_c && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Sync shift chains: stage 0 is the aligned register, the rest add delay.
  generate
    if (SYNC_DLY == 0) begin : g_nodly
      always_comb begin
        hs_pipe_d = hs_lvl_c;
        vs_pipe_d = vs_lvl_c;
      end
    end else begin : g_dly
      always_comb begin
        hs_pipe_d = {hs_pipe_q[PIPE_W-2:0], hs_lvl_c};
        vs_pipe_d = {vs_pipe_q[PIPE_W-2:0], vs_lvl_c};
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      ready_q   <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      fs_q      <= 1'b0;
      hs_pipe_q <= {PIPE_W{~H_POL}};
      vs_pipe_q <= {PIPE_W{~V_POL}};
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      ready_q   <= ready_d;
      col_q     <= col_d;
      row_q     <= row_d;
      fs_q      <= fs_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign Ready_Sig       = ready_q;
  assign Column_Addr_Sig = col_q;
  assign Row_Addr_Sig    = row_q;
  assign Frame_Start     = fs_q;
  assign HSYNC_Sig       = hs_pipe_q[PIPE_W-1];
  assign VSYNC_Sig       = vs_pipe_q[PIPE_W-1];

endmodule
